// File: rtl/cdb_broadcast.sv
// Four-source, two-lane common data bus: per-source result FIFOs with round-robin lane grants.
// Define CDB_BYPASS_EN to let a result arriving at an empty FIFO compete for a lane in the same cycle.
module cdb_broadcast #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [3:0]        fu_valid,
  output logic [3:0]        fu_ready,
  input  logic [3:0][5:0]   fu_pd_idx,
  input  logic [3:0][4:0]   fu_rd_idx,
  input  logic [3:0][3:0]   fu_rob_idx,
  input  logic [3:0][31:0]  fu_value,
  output logic [1:0]        cdb_valid,
  output logic [1:0][5:0]   cdb_pd_s,
  output logic [1:0][31:0]  cdb_pd_v,
  output logic [1:0][3:0]   cdb_rob_idx,
  output logic [1:0][4:0]   cdb_rd_idx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [5:0]  pd;
    logic [4:0]  rd;
    logic [3:0]  rob;
    logic [31:0] val;
  } res_t;

  res_t          mem_q [4][FIFO_DEPTH];
  res_t          mem_d [4][FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q [4];
  logic [PW-1:0] rd_ptr_d [4];
  logic [PW-1:0] wr_ptr_q [4];
  logic [PW-1:0] wr_ptr_d [4];
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [1:0]    rr_q, rr_d;
  logic [1:0]    val_q, val_d;
  res_t          lane_q [2];
  res_t          lane_d [2];

  res_t       inc [4];
  res_t       head [4];
  logic [3:0] acc, req, byp, grant, push, pop;
  logic       found0, found1;
  logic [1:0] g0, g1;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      fu_ready[i] = cnt_q[i] < CW'(FIFO_DEPTH);
    end
  end

  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    val_d     = '0;
    lane_d[0] = '0;
    lane_d[1] = '0;
    found0    = 1'b0;
    found1    = 1'b0;
    g0        = '0;
    g1        = '0;
    grant     = '0;
    push      = '0;
    pop       = '0;

    for (int i = 0; i < 4; i++) begin
      inc[i]  = {fu_pd_idx[i], fu_rd_idx[i],
                 fu_rob_idx[i], fu_value[i]};
      acc[i]  = fu_valid[i] & fu_ready[i] & ~flush;
      head[i] = mem_q[i][rd_ptr_q[i]];
      req[i]  = (cnt_q[i] != '0) & ~flush;
      byp[i]  = 1'b0;
`ifdef CDB_BYPASS_EN
      if (cnt_q[i] == '0 && acc[i]
          && inc[i].pd != '0) begin
        req[i]  = 1'b1;
        byp[i]  = 1'b1;
        head[i] = inc[i];
      end
`endif
    end

    // lane 0 scans from rr; lane 1 resumes just past lane 0's winner
    for (int k = 0; k < 4; k++) begin
      logic [1:0] s;
      s = rr_q + 2'(k);
      if (!found0 && req[s]) begin
        found0 = 1'b1;
        g0     = s;
      end
    end
    for (int k = 1; k < 4; k++) begin
      logic [1:0] s;
      s = g0 + 2'(k);
      if (found0 && !found1 && req[s]) begin
        found1 = 1'b1;
        g1     = s;
      end
    end

    if (found0) begin
      grant[g0] = 1'b1;
      val_d[0]  = 1'b1;
      lane_d[0] = head[g0];
      rr_d      = g0 + 2'd1;
    end
    if (found1) begin
      grant[g1] = 1'b1;
      val_d[1]  = 1'b1;
      lane_d[1] = head[g1];
      rr_d      = g1 + 2'd1;
    end

    for (int i = 0; i < 4; i++) begin
      pop[i]  = grant[i] & ~byp[i];
      push[i] = acc[i] & (inc[i].pd != '0)
              & ~(grant[i] & byp[i]);
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = inc[i];
        wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      end
      cnt_d[i] = cnt_q[i] + CW'(push[i])
               - CW'(pop[i]);
    end

    if (flush) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end
      rr_d      = '0;
      val_d     = '0;
      lane_d[0] = '0;
      lane_d[1] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
      end
      rr_q      <= '0;
      val_q     <= '0;
      lane_q[0] <= '0;
      lane_q[1] <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      rr_q     <= rr_d;
      val_q    <= val_d;
      lane_q   <= lane_d;
    end
  end

  always_comb begin
    cdb_valid = val_q;
    for (int l = 0; l < 2; l++) begin
      cdb_pd_s[l]    = lane_q[l].pd;
      cdb_rd_idx[l]  = lane_q[l].rd;
      cdb_rob_idx[l] = lane_q[l].rob;
      cdb_pd_v[l]    = lane_q[l].val;
    end
  end

endmodule

// File: tb/tb_cdb_broadcast.sv
// Randomised and directed bench for cdb_broadcast against a queue-based model.
module tb_cdb_broadcast;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [5:0]  pd;
    logic [4:0]  rd;
    logic [3:0]  rob;
    logic [31:0] v;
  } ent_t;

  logic             clk, rst, flush;
  logic [3:0]       fu_valid, fu_ready;
  logic [3:0][5:0]  fu_pd_idx;
  logic [3:0][4:0]  fu_rd_idx;
  logic [3:0][3:0]  fu_rob_idx;
  logic [3:0][31:0] fu_value;
  logic [1:0]       cdb_valid;
  logic [1:0][5:0]  cdb_pd_s;
  logic [1:0][31:0] cdb_pd_v;
  logic [1:0][3:0]  cdb_rob_idx;
  logic [1:0][4:0]  cdb_rd_idx;

  cdb_broadcast #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_pd_idx(fu_pd_idx), .fu_rd_idx(fu_rd_idx),
    .fu_rob_idx(fu_rob_idx), .fu_value(fu_value),
    .cdb_valid(cdb_valid), .cdb_pd_s(cdb_pd_s),
    .cdb_pd_v(cdb_pd_v), .cdb_rob_idx(cdb_rob_idx),
    .cdb_rd_idx(cdb_rd_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ent_t       mq [4][$];
  int         rr_m;
  logic [1:0] ev;
  ent_t       el [2];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mq[i].delete();
    rr_m  = 0;
    ev    = '0;
    el[0] = '0;
    el[1] = '0;
  endtask

  // Predicts the state right after the coming rising edge.
  task automatic model_step();
    bit   acc [4];
    bit   cand [4];
    bit   byp [4];
    bit   gr [4];
    ent_t inc [4];
    int   win [2];
    int   ng;
    for (int i = 0; i < 4; i++) begin
      inc[i] = {fu_pd_idx[i], fu_rd_idx[i],
                fu_rob_idx[i], fu_value[i]};
      acc[i] = fu_valid[i] && mq[i].size() < DEPTH;
    end
    if (flush) begin
      model_clear();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      cand[i] = mq[i].size() > 0;
      byp[i]  = 0;
      gr[i]   = 0;
`ifdef CDB_BYPASS_EN
      if (!cand[i] && acc[i] && inc[i].pd != 0) begin
        cand[i] = 1;
        byp[i]  = 1;
      end
`endif
    end
    ng = 0;
    win[0] = 0;
    win[1] = 0;
    for (int k = 0; k < 4; k++) begin
      int s;
      s = (rr_m + k) % 4;
      if (cand[s] && ng < 2) begin
        win[ng] = s;
        gr[s]   = 1;
        ng++;
      end
    end
    ev    = '0;
    el[0] = '0;
    el[1] = '0;
    for (int l = 0; l < ng; l++) begin
      ev[l] = 1'b1;
      el[l] = byp[win[l]] ? inc[win[l]]
                          : mq[win[l]][0];
    end
    for (int l = 0; l < ng; l++)
      if (!byp[win[l]]) void'(mq[win[l]].pop_front());
    for (int i = 0; i < 4; i++)
      if (acc[i] && inc[i].pd != 0 && !(byp[i] && gr[i]))
        mq[i].push_back(inc[i]);
    if (ng > 0) rr_m = (win[ng-1] + 1) % 4;
  endtask

  task automatic compare();
    logic [3:0] er;
    for (int i = 0; i < 4; i++)
      er[i] = mq[i].size() < DEPTH;
    chk("fu_ready", {60'd0, fu_ready}, {60'd0, er});
    for (int l = 0; l < 2; l++)
      chk($sformatf("lane%0d", l),
          {16'd0, cdb_valid[l], cdb_pd_s[l],
           cdb_rd_idx[l], cdb_rob_idx[l], cdb_pd_v[l]},
          {16'd0, ev[l], el[l]});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #2;
    compare();
  endtask

  task automatic set_src(input int i, input logic [5:0] pd,
                         input logic [31:0] v,
                         input logic [3:0] rob,
                         input logic [4:0] rd);
    fu_valid[i]   = 1'b1;
    fu_pd_idx[i]  = pd;
    fu_value[i]   = v;
    fu_rob_idx[i] = rob;
    fu_rd_idx[i]  = rd;
  endtask

  task automatic push_all(input logic [5:0] base);
    for (int i = 0; i < 4; i++)
      set_src(i, base + 6'(i), $urandom,
              4'(i), 5'(i + 1));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  // Reset asserted between edges, released before the next edge.
  task automatic async_reset();
    #1 rst = 1'b0;
    model_clear();
    #1;
    chk("rst_async_valid", {62'd0, cdb_valid}, 64'd0);
    compare();
    @(negedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    bool_loop: begin end
  end

  initial begin
    bit done;
    rst = 1'b0;
    flush = 1'b0;
    fu_valid = '0;
    fu_pd_idx = '0;
    fu_rd_idx = '0;
    fu_rob_idx = '0;
    fu_value = '0;
    model_clear();
    #3;
    chk("reset_ready", {60'd0, fu_ready}, 64'hf);
    chk("reset_valid", {62'd0, cdb_valid}, 64'd0);
    compare();
    #9 rst = 1'b1;

    // single alu result
    set_src(0, 6'd5, 32'h1eceb000, 4'd2, 5'd3);
    tick();
    fu_valid = '0;
`ifndef CDB_BYPASS_EN
    tick();
`endif
    chk("alu_valid", {62'd0, cdb_valid}, 64'h1);
    chk("alu_pd", {58'd0, cdb_pd_s[0]}, 64'd5);
    chk("alu_val", {32'd0, cdb_pd_v[0]}, 64'h1eceb000);
    chk("alu_rob", {60'd0, cdb_rob_idx[0]}, 64'd2);
    chk("alu_l1_pd", {58'd0, cdb_pd_s[1]}, 64'd0);
    tick();
    tick();

    // all four sources on one edge, rr starting at 0
    do_flush();
    push_all(6'd1);
    tick();
    fu_valid = '0;
`ifndef CDB_BYPASS_EN
    tick();
`endif
    chk("rr_c1_valid", {62'd0, cdb_valid}, 64'h3);
    chk("rr_c1_l0", {58'd0, cdb_pd_s[0]}, 64'd1);
    chk("rr_c1_l1", {58'd0, cdb_pd_s[1]}, 64'd2);
    tick();
    chk("rr_c2_l0", {58'd0, cdb_pd_s[0]}, 64'd3);
    chk("rr_c2_l1", {58'd0, cdb_pd_s[1]}, 64'd4);
    tick();
    chk("rr_c3_valid", {62'd0, cdb_valid}, 64'd0);
    // rr back at 0: source 0 again wins lane 0
    push_all(6'd5);
    tick();
    fu_valid = '0;
`ifndef CDB_BYPASS_EN
    tick();
`endif
    chk("rr_wrap_l0", {58'd0, cdb_pd_s[0]}, 64'd5);
    repeat (3) tick();

    // div back-pressure and hold
    do_flush();
    push_all(6'd10);
    tick();
    push_all(6'd20);
    tick();
`ifndef CDB_BYPASS_EN
    chk("div_full_ready", {60'd0, fu_ready}, 64'h3);
`endif
    fu_valid = '0;
    set_src(3, 6'd33, 32'hd1d1d1d1, 4'd9, 5'd17);
    done = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      if (fu_ready[3]) done = 1;
      tick();
    end
    chk("div_hold_accept", {63'd0, done}, 64'd1);
    fu_valid = '0;
    repeat (4) tick();

    // zero destination is dropped
    set_src(2, 6'd0, 32'hbad0bad0, 4'd1, 5'd1);
    repeat (4) begin
      tick();
      chk("pd0_ready", {60'd0, fu_ready}, 64'hf);
      chk("pd0_valid", {62'd0, cdb_valid}, 64'd0);
    end
    fu_valid = '0;
    repeat (2) tick();

    // flush over full buffers
    push_all(6'd40);
    tick();
    push_all(6'd48);
    tick();
    do_flush();
    fu_valid = '0;
    chk("flush_valid", {62'd0, cdb_valid}, 64'd0);
    chk("flush_ready", {60'd0, fu_ready}, 64'hf);
    repeat (3) begin
      tick();
      chk("flush_stale", {62'd0, cdb_valid}, 64'd0);
    end

    // async reset mid-burst
    push_all(6'd50);
    tick();
    push_all(6'd56);
    tick();
    async_reset();
    fu_valid = '0;
    repeat (4) begin
      tick();
      chk("rst_stale", {62'd0, cdb_valid}, 64'd0);
    end

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        logic [5:0] pd;
        pd = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom);
        fu_valid[i]   = 1'($urandom);
        fu_pd_idx[i]  = pd;
        fu_value[i]   = $urandom;
        fu_rob_idx[i] = 4'($urandom);
        fu_rd_idx[i]  = 5'($urandom);
      end
      flush = ($urandom_range(49) == 0);
      if ($urandom_range(299) == 0) async_reset();
      tick();
    end
    flush = 1'b0;
    fu_valid = '0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
